// File: rtl/jtag_cmd_chain_if.sv
// jtag_cmd_chain_if
//   Fabric-side handshake bundle for jtag_cmd_chain. It carries the TX FIFO
//   (JTAG to fabric) and the RX FIFO (fabric to JTAG) streams.
//   Ports (signals):
//     tx_data  [DATA_W] : head of the TX FIFO
//     tx_valid          : TX FIFO not empty
//     tx_ready          : fabric pops TX when tx_valid & tx_ready
//     rx_data  [DATA_W] : fabric write data for the RX FIFO
//     rx_valid          : fabric push request
//     rx_ready          : RX FIFO not full
//   Modports:
//     master : the command chain (sources TX, sinks RX)
//     slave  : the fabric side
interface jtag_cmd_chain_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/jtag_cmd_chain.sv
// jtag_cmd_chain
//   Parametrised JTAG user-chain command decoder. A chain word is shifted in
//   LSB-first; on update, the low OP_W bits are an opcode and the next DATA_W
//   bits a payload. Opcodes load the address / byte-enable / burst-size
//   registers, push into the TX FIFO, pop the RX FIFO, pick the readback
//   source and clear the sticky flags. The selected readback word is loaded
//   into the shift register on the next capture.
//   Optional feature macro: JTAG_CHAIN_PARITY_EN adds an even-parity MSB to
//   the chain; a word with bad parity is ignored and sets par_err.
//   Ports:
//     JTCK, JRST        : chain clock (rising edge), async active-high reset
//     JTDI, JTD1        : serial in / serial out (JTD1 = sr[0])
//     JSHIFT, JUPDATE   : shift-DR state, update-DR pulse
//     JCE1              : chain-1 enable (capture and shift)
//     address_out       : address register
//     byte_en_out       : byte-enable register
//     burst_size_out    : burst-size register
//     fab               : TX/RX FIFO handshakes (jtag_cmd_chain_if.master)
module jtag_cmd_chain #(
  parameter int DATA_W   = 32,
  parameter int OP_W     = 4,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int BE_W     = 4
) (
  input  logic              JTCK,
  input  logic              JRST,
  input  logic              JTDI,
  input  logic              JSHIFT,
  input  logic              JUPDATE,
  input  logic              JCE1,
  output logic              JTD1,
  output logic [DATA_W-1:0] address_out,
  output logic [BE_W-1:0]   byte_en_out,
  output logic [7:0]        burst_size_out,
  jtag_cmd_chain_if.master  fab
);

`ifdef JTAG_CHAIN_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int CORE_W = DATA_W + OP_W;
  localparam int CW     = CORE_W + PAR_W;
  localparam int TX_AW  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int RX_AW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int TX_CW  = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW  = $clog2(RX_DEPTH) + 1;

  localparam logic [OP_W-1:0] OP_SET_ADDR  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SET_BE    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SET_BURST = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SEL_ADDR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SEL_BB    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SEL_STAT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_TX_PUSH   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_RX_POP    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_CLR_FLAGS = OP_W'(15);

  typedef enum logic [1:0] {
    SEL_ADDR,
    SEL_BB,
    SEL_STATUS,
    SEL_RX
  } sel_e;

  logic [CW-1:0]     sr_q, sr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [7:0]        burst_q, burst_d;
  sel_e              sel_q, sel_d;
  logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_unf_q, rx_unf_d;
  logic              par_err_q, par_err_d;

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] tx_mem_d [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;

  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [DATA_W-1:0] rx_mem_d [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;

  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_pop, rx_push, tx_push, rx_pop;
  logic              upd_ok;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] pl;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] resp;
  logic [CORE_W-1:0] cap_core;

  function automatic logic [TX_AW-1:0] tx_inc(input logic [TX_AW-1:0] p);
    return (p == TX_AW'(TX_DEPTH - 1)) ? '0 : p + TX_AW'(1);
  endfunction

  function automatic logic [RX_AW-1:0] rx_inc(input logic [RX_AW-1:0] p);
    return (p == RX_AW'(RX_DEPTH - 1)) ? '0 : p + RX_AW'(1);
  endfunction

  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // Fabric-side handshakes are evaluated on pre-edge state.
  assign tx_pop  = !tx_empty && fab.tx_ready;
  assign rx_push = !rx_full && fab.rx_valid;

  assign op = sr_q[OP_W-1:0];
  assign pl = sr_q[OP_W +: DATA_W];

  // Even parity: the XOR over the whole chain word must be zero.
`ifdef JTAG_CHAIN_PARITY_EN
  assign upd_ok = ~(^sr_q);
`else
  assign upd_ok = 1'b1;
`endif

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[4]     = tx_ovf_q;
    status[5]     = rx_unf_q;
    status[6]     = par_err_q;
    status[15:8]  = 8'(tx_cnt_q);
    status[23:16] = 8'(rx_cnt_q);
  end

  always_comb begin
    case (sel_q)
      SEL_ADDR: resp = addr_q;
      SEL_BB:   resp = DATA_W'({burst_q, be_q});
      SEL_RX:   resp = rx_hold_q;
      default:  resp = status;
    endcase
  end

  // The status low bits ride in the opcode field of every captured word.
  assign cap_core = {resp, status[OP_W-1:0]};

  // Next-state logic: chain shift/capture, update decode, then both FIFOs.
  always_comb begin
    sr_d      = sr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    burst_d   = burst_q;
    sel_d     = sel_q;
    rx_hold_d = rx_hold_q;
    tx_ovf_d  = tx_ovf_q;
    rx_unf_d  = rx_unf_q;
    par_err_d = par_err_q;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;

    if (JCE1) begin
      if (JSHIFT) begin
        sr_d = {JTDI, sr_q[CW-1:1]};
      end else begin
`ifdef JTAG_CHAIN_PARITY_EN
        sr_d = {^cap_core, cap_core};
`else
        sr_d = cap_core;
`endif
      end
    end else if (JUPDATE) begin
      if (!upd_ok) begin
        par_err_d = 1'b1;
      end else begin
        case (op)
          OP_SET_ADDR:  addr_d  = pl;
          OP_SET_BE:    be_d    = pl[BE_W-1:0];
          OP_SET_BURST: burst_d = pl[7:0];
          OP_SEL_ADDR:  sel_d   = SEL_ADDR;
          OP_SEL_BB:    sel_d   = SEL_BB;
          OP_SEL_STAT:  sel_d   = SEL_STATUS;
          OP_TX_PUSH: begin
            // A full FIFO still accepts the word if the fabric frees a slot on this edge.
            if (tx_full && !tx_pop) tx_ovf_d = 1'b1;
            else                    tx_push  = 1'b1;
          end
          OP_RX_POP: begin
            sel_d = SEL_RX;
            if (rx_empty) begin
              rx_hold_d = '0;
              rx_unf_d  = 1'b1;
            end else begin
              rx_hold_d = rx_mem_q[rx_rd_q];
              rx_pop    = 1'b1;
            end
          end
          OP_CLR_FLAGS: begin
            tx_ovf_d  = 1'b0;
            rx_unf_d  = 1'b0;
            par_err_d = 1'b0;
          end
          default: ;
        endcase
      end
    end

    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = pl;
      tx_wr_d           = tx_inc(tx_wr_q);
    end
    if (tx_pop) tx_rd_d = tx_inc(tx_rd_q);
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TX_CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CW'(1);

    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = fab.rx_data;
      rx_wr_d           = rx_inc(rx_wr_q);
    end
    if (rx_pop) rx_rd_d = rx_inc(rx_rd_q);
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RX_CW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_CW'(1);
  end

  // All state, including FIFO storage, clears on reset; a partial shift is lost.
  always_ff @(posedge JTCK or posedge JRST) begin
    if (JRST) begin
      sr_q      <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      burst_q   <= '0;
      sel_q     <= SEL_STATUS;
      rx_hold_q <= '0;
      tx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      par_err_q <= 1'b0;
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      sr_q      <= sr_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      burst_q   <= burst_d;
      sel_q     <= sel_d;
      rx_hold_q <= rx_hold_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_unf_q  <= rx_unf_d;
      par_err_q <= par_err_d;
      tx_mem_q  <= tx_mem_d;
      rx_mem_q  <= rx_mem_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  assign JTD1           = sr_q[0];
  assign address_out    = addr_q;
  assign byte_en_out    = be_q;
  assign burst_size_out = burst_q;
  assign fab.tx_data    = tx_mem_q[tx_rd_q];
  assign fab.tx_valid   = !tx_empty;
  assign fab.rx_ready   = !rx_full;

endmodule
